// File: rtl/axi_wr_mem_sink_pkg.sv
// Shared definitions for the AXI write path: FSM states, commit counter width, BRESP codes.
// Optional debug read port of axi_wr_mem_sink is enabled by defining DBG_RD_EN.
package axi_wr_mem_sink_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_e;

  localparam int WRCNT_W = 16;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // Width of a down-counter that must hold values 0..cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/axi_wr_mem_sink_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; full/empty come from a
// registered occupancy count so they never depend on same-cycle push/pop.
module sync_fifo #(
  parameter int WIDTH = 40,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A push while full is refused even if a pop happens in the same cycle.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/axi_wr_mem_sink.sv
// Backing store behind the AXI write slave: buffers beats in a FIFO and commits them to a word
// memory through a slow fixed-latency port. Define DBG_RD_EN to add the dbg_addr/dbg_data read port.
module axi_wr_mem_sink
  import axi_wr_mem_sink_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_AW      = 8,
  parameter int FIFO_AW     = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [DATA_W-1:0]    Dataout,
  input  logic [ADDR_W-1:0]    addressout,
  input  logic                 writeavail,
  output logic                 finishwrite,
  output logic                 busy,
  output logic [WRCNT_W-1:0]   wr_count,
  output logic                 err_oob
`ifdef DBG_RD_EN
  ,
  input  logic [MEM_AW-1:0]    dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
`endif
);

  localparam int CNT_W    = cnt_width(WAIT_CYCLES);
  localparam int ENTRY_W  = MEM_AW + DATA_W;
  localparam int MEM_WORDS = 1 << MEM_AW;

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [WRCNT_W-1:0]    wr_count_q, wr_count_d;
  logic                  err_q, err_d;

  logic [DATA_W-1:0]     mem_q [MEM_WORDS];

  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic                  accept, in_range, commit;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^addressout[1:0];

  assign in_range  = (addressout[ADDR_W-1:MEM_AW+2] == '0);
  assign accept    = writeavail && !fifo_full;
  assign fifo_push = accept && in_range;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({addressout[MEM_AW+1:2], Dataout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Commit at counter==0 can immediately pop the next entry so bursts drain without a bubble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    commit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop        = 1'b1;
          {idx_d, data_d} = fifo_dout;
          cnt_d           = CNT_W'(WAIT_CYCLES - 1);
          state_d         = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          commit = 1'b1;
          if (!fifo_empty) begin
            fifo_pop        = 1'b1;
            {idx_d, data_d} = fifo_dout;
            cnt_d           = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_count_d = wr_count_q + WRCNT_W'(commit);
    err_d      = err_q || (accept && !in_range);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge ACLK) begin
    if (commit) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign finishwrite = !fifo_full;
  assign busy        = (state_q == S_WRITE) || !fifo_empty;
  assign wr_count    = wr_count_q;
  assign err_oob     = err_q;

`ifdef DBG_RD_EN
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

  always_comb begin
    dbg_data_d = mem_q[dbg_addr];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      dbg_data_q <= '0;
    end else begin
      dbg_data_q <= dbg_data_d;
    end
  end

  assign dbg_data = dbg_data_q;
`else
  logic unused_mem;
  assign unused_mem = ^mem_q[0];
`endif

endmodule

// File: tb/tb_axi_wr_mem_sink.sv
// Randomized scoreboard bench for axi_wr_mem_sink: driver queues expected commits, a negedge
// monitor checks each commit's order, data, timing, plus busy/err_oob every cycle.
module tb_axi_wr_mem_sink;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int MEM_AW      = 8;
  localparam int WAIT_CYCLES = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [DATA_W-1:0] Dataout;
  logic [ADDR_W-1:0] addressout;
  logic              writeavail;
  logic              finishwrite;
  logic              busy;
  logic [15:0]       wr_count;
  logic              err_oob;
`ifdef DBG_RD_EN
  logic [MEM_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
`endif

  always #5 ACLK = ~ACLK;

  axi_wr_mem_sink dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .Dataout     (Dataout),
    .addressout  (addressout),
    .writeavail  (writeavail),
    .finishwrite (finishwrite),
    .busy        (busy),
    .wr_count    (wr_count),
    .err_oob     (err_oob)
`ifdef DBG_RD_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          ready_cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] model_mem[int];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_commit = -1000;
  logic [15:0] cnt_exp = '0;
  logic        err_exp = 1'b0;
  bit          mon_en = 1'b0;
  bit          saw_full = 1'b0;
  int          n_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a commit is due WAIT_CYCLES+1 edges after its push, and no sooner than
  // WAIT_CYCLES edges after the previous commit.
  always @(negedge ACLK) begin
    cyc++;
    if (mon_en && ARESETn) begin
      if (wr_count != cnt_exp) begin
        check("commit_step", 64'(wr_count), 64'(cnt_exp + 16'd1));
        cnt_exp = cnt_exp + 16'd1;
        if (exp_q.size() == 0) begin
          check("commit_unexpected", 64'(1), 64'(0));
        end else begin
          beat_t b;
          int due;
          b = exp_q.pop_front();
          due = b.ready_cyc + WAIT_CYCLES + 1;
          if (last_commit + WAIT_CYCLES > due) due = last_commit + WAIT_CYCLES;
          check("commit_data", 64'(dut.mem_q[b.idx]), 64'(b.data));
          check("commit_cycle", 64'(cyc), 64'(due));
          last_commit = cyc;
          $display("commit idx=%0d data=%08h cyc=%0d", b.idx, b.data, cyc);
        end
      end
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("err_oob", 64'(err_oob), 64'(err_exp));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    bit done = 1'b0;
    @(negedge ACLK);
    addressout = a;
    Dataout    = d;
    writeavail = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      if (finishwrite) done = 1'b1;
      else saw_full = 1'b1;
      @(posedge ACLK);
      if (!done) @(negedge ACLK);
    end
    if (!done) begin
      check("accept_timeout", 64'(0), 64'(1));
    end else if (a[31:MEM_AW+2] != '0) begin
      err_exp = 1'b1;
      $display("beat addr=%08h data=%08h dropped (out of range)", a, d);
    end else begin
      beat_t b;
      b.idx       = int'(a[MEM_AW+1:2]);
      b.data      = d;
      b.ready_cyc = cyc + 1;
      exp_q.push_back(b);
      model_mem[b.idx] = d;
      n_acc++;
    end
  endtask

  task automatic idle(input int n);
    @(negedge ACLK);
    writeavail = 1'b0;
    for (int k = 1; k < n; k++) @(negedge ACLK);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    idle(1);
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      @(negedge ACLK);
      k++;
    end
    @(negedge ACLK);
    check({"drain_", tag}, 64'(k < 300), 64'(1));
    check({"count_", tag}, 64'(wr_count), 64'(n_acc));
  endtask

  task automatic check_mem();
    foreach (model_mem[i]) check($sformatf("mem[%0d]", i), 64'(dut.mem_q[i]), 64'(model_mem[i]));
  endtask

  initial begin
    ARESETn    = 1'b0;
    writeavail = 1'b0;
    Dataout    = '0;
    addressout = '0;
`ifdef DBG_RD_EN
    dbg_addr   = '0;
`endif
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_finishwrite", 64'(finishwrite), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_count", 64'(wr_count), 64'(0));
    check("rst_err_oob", 64'(err_oob), 64'(0));
`ifdef DBG_RD_EN
    check("rst_dbg_data", 64'(dbg_data), 64'(0));
`endif
    mon_en = 1'b1;

    send(32'h8, 32'h1);
    drain("single");
    check("single_mem2", 64'(dut.mem_q[2]), 64'(1));

    for (int i = 0; i < 4; i++) send(32'(i * 4), 32'(i + 1));
    drain("burst");
    for (int i = 0; i < 4; i++) check($sformatf("burst_mem%0d", i), 64'(dut.mem_q[i]), 64'(i + 1));

    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) send(32'((16 + i) * 4), $urandom);
    drain("overflow");
    check("overflow_full_seen", 64'(saw_full), 64'(1));

    send(32'h400, 32'hDEAD_BEEF);
    drain("oob");
    check("oob_sticky", 64'(err_oob), 64'(1));

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) a[31:MEM_AW+2] = 22'($urandom_range(1, 3));
      send(a, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    drain("random");
    check_mem();

    for (int i = 0; i < 4; i++) send(32'((40 + i) * 4), $urandom);
    #2;
    ARESETn = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_finishwrite", 64'(finishwrite), 64'(1));
    check("midrst_wr_count", 64'(wr_count), 64'(0));
    check("midrst_err_oob", 64'(err_oob), 64'(0));
    foreach (exp_q[i]) model_mem.delete(exp_q[i].idx);
    exp_q.delete();
    cnt_exp     = '0;
    err_exp     = 1'b0;
    n_acc       = 0;
    last_commit = -1000;
    writeavail  = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
`ifdef DBG_RD_EN
    dbg_addr = 8'd2;
    @(negedge ACLK);
    @(negedge ACLK);
    if (model_mem.exists(2)) check("dbg_data_2", 64'(dbg_data), 64'(model_mem[2]));
`endif
    send(32'h14, 32'h1234_5678);
    drain("post_reset");
    check("post_reset_mem5", 64'(dut.mem_q[5]), 64'(32'h1234_5678));
    check_mem();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
